// File: rtl/gpu_column_fetcher.sv
// gpu_column_fetcher
// Reads one frame of raycast column data (distance + texture UV) from the
// double-buffered region that the CPU is not currently writing. It then
// streams the columns one record at a time to the column renderer using a
// valid/ready handshake.
// It also publishes the GPU flags word that the CPU reads back at 0xffff.
//
// Memory read port timing: the address is registered inside the memory, so
// data for the address driven in cycle t appears on memData in cycle t+1.
// Per column, the FSM goes DIST -> UV -> LAST -> PRESENT:
//   DIST    : drive the distance address
//   UV      : drive the UV address, capture the distance word
//   LAST    : capture the UV word
//   PRESENT : hold the record valid until the renderer accepts it
module gpu_column_fetcher #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned COLUMNS    = 320,
  parameter logic [ADDR_WIDTH-1:0] BUF0_BASE = 16'hf800,
  parameter logic [ADDR_WIDTH-1:0] BUF1_BASE = 16'hfc00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frameStart,
  output logic [ADDR_WIDTH-1:0] memAddress,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic                  colValid,
  input  logic                  colReady,
  output logic [8:0]            colIndex,
  output logic [DATA_WIDTH-1:0] colDistance,
  output logic [DATA_WIDTH-1:0] colUV,
  output logic [DATA_WIDTH-1:0] gpuFlags
);

  // The UV table sits 0x200 words above the distance table in each buffer.
  localparam logic [ADDR_WIDTH-1:0] UV_OFFSET = ADDR_WIDTH'('h200);
  localparam logic [8:0]            LAST_COL  = 9'(COLUMNS - 1);

  typedef enum logic [2:0] {
    IDLE,
    DIST,
    UV,
    LAST,
    PRESENT
  } state_t;

  state_t state;
  state_t state_next;

  logic                  read_buf;
  logic                  parity;
  logic                  overrun;
  logic [8:0]            col;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [DATA_WIDTH-1:0] dist_word;
  logic [DATA_WIDTH-1:0] uv_word;

  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] col_ext;
  logic                  busy;
  logic                  accept;
  logic                  last_col;

  assign base     = read_buf ? BUF1_BASE : BUF0_BASE;
  assign col_ext  = {{(ADDR_WIDTH-9){1'b0}}, col};
  assign busy     = (state != IDLE);
  assign accept   = (state == PRESENT) && colReady;
  assign last_col = (col == LAST_COL);

  // State register for the fetch sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A frameStart pulse always restarts the fetch. This
  // covers both the normal start from IDLE and a frame overrun that
  // abandons a partial frame, even if a record is being accepted that
  // same cycle.
  always_comb begin
    state_next = state;
    if (frameStart) begin
      state_next = DIST;
    end else begin
      unique case (state)
        IDLE:    state_next = IDLE;
        DIST:    state_next = UV;
        UV:      state_next = LAST;
        LAST:    state_next = PRESENT;
        PRESENT: begin
          if (colReady) begin
            state_next = last_col ? IDLE : DIST;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode. The memory address is only actively driven in the two
  // address phases. In every other state it holds the last address that
  // was presented, so that the memory port stays quiet.
  always_comb begin
    memAddress = addr_hold;
    colValid   = 1'b0;
    unique case (state)
      DIST:    memAddress = base + col_ext;
      UV:      memAddress = base + UV_OFFSET + col_ext;
      PRESENT: colValid   = 1'b1;
      default: ;
    endcase
  end

  // Frame bookkeeping.
  // Each frame start swaps buffers and flips parity. A start that arrives
  // while still busy marks a sticky overrun. Only a clean start from IDLE
  // clears that overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_buf <= 1'b0;
      parity   <= 1'b0;
      overrun  <= 1'b0;
      col      <= '0;
    end else if (frameStart) begin
      read_buf <= ~read_buf;
      parity   <= ~parity;
      overrun  <= busy;
      col      <= '0;
    end else if (accept && !last_col) begin
      col      <= col + 9'd1;
    end
  end

  // Data path: remember the last driven address, and capture the two
  // words of the column record as they return from the memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_hold <= '0;
      dist_word <= '0;
      uv_word   <= '0;
    end else begin
      addr_hold <= memAddress;
      if (state == UV) begin
        dist_word <= memData;
      end
      if (state == LAST) begin
        uv_word <= memData;
      end
    end
  end

  assign colIndex    = col;
  assign colDistance = dist_word;
  assign colUV       = uv_word;

  // Bit 0 tells the CPU which buffer it may write (the one not being read).
  assign gpuFlags = {{(DATA_WIDTH-4){1'b0}}, busy, overrun, parity, ~read_buf};

endmodule

// File: tb/tb_gpu_column_fetcher.sv
// Testbench for gpu_column_fetcher.
// A registered-read memory model feeds the DUT.
// Each scenario task drives one frame and compares the streamed records
// against values computed from the buffer layout and the frame/flag rules.
module tb_gpu_column_fetcher;

  localparam int COLS = 320;

  logic        clk = 1'b0;
  logic        reset;
  logic        frameStart;
  logic [15:0] memAddress;
  logic [15:0] memData;
  logic        colValid;
  logic        colReady;
  logic [8:0]  colIndex;
  logic [15:0] colDistance;
  logic [15:0] colUV;
  logic [15:0] gpuFlags;

  logic [15:0] ram [0:65535];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Expected frame state: current read buffer, parity, sticky overrun.
  logic m_rb, m_par, m_ov;

  gpu_column_fetcher dut (
    .clk        (clk),
    .reset      (reset),
    .frameStart (frameStart),
    .memAddress (memAddress),
    .memData    (memData),
    .colValid   (colValid),
    .colReady   (colReady),
    .colIndex   (colIndex),
    .colDistance(colDistance),
    .colUV      (colUV),
    .gpuFlags   (gpuFlags)
  );

  always #5 clk = ~clk;

  // Memory with a registered read address: data arrives one cycle later.
  always @(posedge clk) memData <= ram[memAddress];

  function automatic logic [15:0] base_of(input logic rb);
    return rb ? 16'hfc00 : 16'hf800;
  endfunction

  function automatic logic [15:0] flags_of(input logic busy);
    return {12'h000, busy, m_ov, m_par, ~m_rb};
  endfunction

  function automatic logic [40:0] exp_rec(input int i);
    logic [15:0] b;
    b = base_of(m_rb);
    return {9'(i), ram[b + 16'(i)], ram[b + 16'h0200 + 16'(i)]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_frame_start(input logic from_idle);
    m_rb  = ~m_rb;
    m_par = ~m_par;
    m_ov  = from_idle ? 1'b0 : 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; frameStart = 1'b0; colReady = 1'b0;
    step(); step();
    reset = 1'b0;
    m_rb = 1'b0; m_par = 1'b0; m_ov = 1'b0;
    compared++;
    if ({memAddress, colIndex, colDistance, colUV} !== 57'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got addr=%h idx=%0d dist=%h uv=%h expected all zero",
               memAddress, colIndex, colDistance, colUV);
    end
    for (int k = 0; k < 10; k++) begin
      compared++;
      if (gpuFlags !== 16'h0001 || colValid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_idle: cycle %0d got flags=%h valid=%b expected flags=0001 valid=0",
                 k, gpuFlags, colValid);
      end
      step();
    end
  endtask

  task automatic test_full_frame();
    int t0, n, last_valid;
    colReady = 1'b1;
    frameStart = 1'b1; model_frame_start(1'b1); t0 = cyc; step(); frameStart = 1'b0;
    compared++;
    if (memAddress !== 16'hfc00) begin
      mismatched++; $display("[TB] FAIL full_dist_addr: got %h expected fc00", memAddress);
    end
    compared++;
    if (gpuFlags !== 16'h000a) begin
      mismatched++; $display("[TB] FAIL full_flags_busy: got %h expected 000a", gpuFlags);
    end
    step();
    compared++;
    if (memAddress !== 16'hfe00) begin
      mismatched++; $display("[TB] FAIL full_uv_addr: got %h expected fe00", memAddress);
    end
    step();
    compared++;
    if (colValid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL full_early_valid: got %b expected 0", colValid);
    end
    step();
    last_valid = -1;
    for (int i = 0; i < COLS; i++) begin
      n = 0;
      while (colValid !== 1'b1 && n < 8) begin step(); n++; end
      compared++;
      if (colValid !== 1'b1) begin
        mismatched++; $display("[TB] FAIL full_timeout: column %0d never valid", i); break;
      end
      compared++;
      if (cyc - t0 != 4 + 4 * i) begin
        mismatched++; $display("[TB] FAIL full_pace: column %0d valid at %0d expected %0d", i, cyc - t0, 4 + 4 * i);
      end
      compared++;
      if ({colIndex, colDistance, colUV} !== {9'(i), 16'h1000 + 16'(i), 16'h2000 + 16'(i)}) begin
        mismatched++;
        $display("[TB] FAIL full_record: got idx=%0d dist=%h uv=%h expected idx=%0d dist=%h uv=%h",
                 colIndex, colDistance, colUV, i, 16'h1000 + 16'(i), 16'h2000 + 16'(i));
      end
      compared++;
      if (gpuFlags !== 16'h000a) begin
        mismatched++; $display("[TB] FAIL full_flags_during: got %h expected 000a", gpuFlags);
      end
      last_valid = cyc - t0;
      step();
    end
    compared++;
    if (last_valid != 4 * COLS) begin
      mismatched++; $display("[TB] FAIL full_last_accept: got %0d expected %0d", last_valid, 4 * COLS);
    end
    compared++;
    if (gpuFlags !== 16'h0002 || colValid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL full_flags_after: got flags=%h valid=%b expected 0002 / 0", gpuFlags, colValid);
    end
    step(); step();
  endtask

  // Second frame: the other buffer (random data), with random backpressure.
  task automatic test_second_frame();
    int n, waits;
    logic acc;
    colReady = 1'b0;
    frameStart = 1'b1; model_frame_start(1'b1); step(); frameStart = 1'b0;
    compared++;
    if (memAddress !== 16'hf800 || gpuFlags[1:0] !== 2'b01) begin
      mismatched++; $display("[TB] FAIL second_start: got addr=%h flags=%h expected addr=f800 flags[1:0]=01", memAddress, gpuFlags);
    end
    step();
    compared++;
    if (memAddress !== 16'hfa00) begin
      mismatched++; $display("[TB] FAIL second_uv_addr: got %h expected fa00", memAddress);
    end
    for (int i = 0; i < COLS; i++) begin
      n = 0;
      while (colValid !== 1'b1 && n < 8) begin step(); n++; end
      compared++;
      if (colValid !== 1'b1) begin
        mismatched++; $display("[TB] FAIL second_timeout: column %0d never valid", i); break;
      end
      waits = 0;
      do begin
        compared++;
        if ({colIndex, colDistance, colUV} !== exp_rec(i) || gpuFlags !== flags_of(1'b1) || colValid !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL second_record: got v=%b idx=%0d dist=%h uv=%h flags=%h expected idx=%0d rec=%h flags=%h",
                   colValid, colIndex, colDistance, colUV, gpuFlags, i, exp_rec(i), flags_of(1'b1));
        end
        acc = (waits > 20) ? 1'b1 : 1'($urandom_range(0, 1));
        colReady = acc;
        step();
        waits++;
      end while (!acc);
      colReady = 1'b0;
    end
    compared++;
    if (gpuFlags !== flags_of(1'b0)) begin
      mismatched++; $display("[TB] FAIL second_flags_after: got %h expected %h", gpuFlags, flags_of(1'b0));
    end
    step(); step();
  endtask

  task automatic test_backpressure();
    int n, acc_cyc;
    logic [15:0] held_addr;
    colReady = 1'b1;
    frameStart = 1'b1; model_frame_start(1'b1); step(); frameStart = 1'b0;
    acc_cyc = -1;
    for (int i = 0; i < COLS; i++) begin
      n = 0;
      while (colValid !== 1'b1 && n < 8) begin step(); n++; end
      compared++;
      if (colValid !== 1'b1) begin
        mismatched++; $display("[TB] FAIL bp_timeout: column %0d never valid", i); break;
      end
      if (i == 6) begin
        compared++;
        if (cyc - acc_cyc != 4) begin
          mismatched++; $display("[TB] FAIL bp_next_latency: got %0d expected 4", cyc - acc_cyc);
        end
      end
      compared++;
      if ({colIndex, colDistance, colUV} !== exp_rec(i)) begin
        mismatched++; $display("[TB] FAIL bp_record: got idx=%0d dist=%h uv=%h expected %h", colIndex, colDistance, colUV, exp_rec(i));
      end
      if (i == 5) begin
        colReady = 1'b0;
        held_addr = memAddress;
        for (int k = 0; k < 7; k++) begin
          step();
          compared++;
          if (colValid !== 1'b1 || {colIndex, colDistance, colUV} !== exp_rec(5) || memAddress !== held_addr) begin
            mismatched++;
            $display("[TB] FAIL bp_hold: got v=%b idx=%0d dist=%h uv=%h addr=%h expected v=1 rec=%h addr=%h",
                     colValid, colIndex, colDistance, colUV, memAddress, exp_rec(5), held_addr);
          end
        end
        colReady = 1'b1;
        acc_cyc = cyc;
      end
      step();
      if (i == 5) begin
        compared++;
        if (colValid !== 1'b0) begin
          mismatched++; $display("[TB] FAIL bp_drop_valid: got %b expected 0", colValid);
        end
      end
    end
    step(); step();
  endtask

  task automatic test_overrun();
    int n, t0;
    colReady = 1'b1;
    frameStart = 1'b1; model_frame_start(1'b1); step(); frameStart = 1'b0;
    for (int i = 0; i <= 100; i++) begin
      n = 0;
      while (colValid !== 1'b1 && n < 8) begin step(); n++; end
      compared++;
      if (colValid !== 1'b1 || {colIndex, colDistance, colUV} !== exp_rec(i)) begin
        mismatched++; $display("[TB] FAIL ovr_pre_record: got v=%b idx=%0d expected idx=%0d rec=%h", colValid, colIndex, i, exp_rec(i));
      end
      if (i < 100) step();
    end
    frameStart = 1'b1; model_frame_start(1'b0); t0 = cyc; step(); frameStart = 1'b0;
    compared++;
    if (colValid !== 1'b0 || gpuFlags !== flags_of(1'b1) || gpuFlags[2] !== 1'b1) begin
      mismatched++; $display("[TB] FAIL ovr_event: got v=%b flags=%h expected v=0 flags=%h", colValid, gpuFlags, flags_of(1'b1));
    end
    compared++;
    if (memAddress !== base_of(m_rb)) begin
      mismatched++; $display("[TB] FAIL ovr_restart_addr: got %h expected %h", memAddress, base_of(m_rb));
    end
    for (int i = 0; i < COLS; i++) begin
      n = 0;
      while (colValid !== 1'b1 && n < 8) begin step(); n++; end
      compared++;
      if (colValid !== 1'b1) begin
        mismatched++; $display("[TB] FAIL ovr_timeout: column %0d never valid", i); break;
      end
      if (i == 0) begin
        compared++;
        if (cyc - t0 != 4) begin
          mismatched++; $display("[TB] FAIL ovr_restart_latency: got %0d expected 4", cyc - t0);
        end
      end
      compared++;
      if ({colIndex, colDistance, colUV} !== exp_rec(i) || gpuFlags !== flags_of(1'b1)) begin
        mismatched++;
        $display("[TB] FAIL ovr_record: got idx=%0d dist=%h uv=%h flags=%h expected rec=%h flags=%h",
                 colIndex, colDistance, colUV, gpuFlags, exp_rec(i), flags_of(1'b1));
      end
      step();
    end
    compared++;
    if (gpuFlags !== flags_of(1'b0) || gpuFlags[2] !== 1'b1) begin
      mismatched++; $display("[TB] FAIL ovr_sticky_idle: got %h expected %h", gpuFlags, flags_of(1'b0));
    end
    step();
    frameStart = 1'b1; model_frame_start(1'b1); step(); frameStart = 1'b0;
    compared++;
    if (gpuFlags !== flags_of(1'b1) || gpuFlags[2] !== 1'b0) begin
      mismatched++; $display("[TB] FAIL ovr_clear: got %h expected %h", gpuFlags, flags_of(1'b1));
    end
  endtask

  // Continues the frame started at the end of test_overrun; reset at column 50.
  task automatic test_reset_mid();
    int n, t0;
    colReady = 1'b1;
    n = 0;
    while (!(colValid === 1'b1 && colIndex === 9'd50) && n < 400) begin step(); n++; end
    compared++;
    if (colValid !== 1'b1 || colIndex !== 9'd50) begin
      mismatched++; $display("[TB] FAIL rmid_reach: got v=%b idx=%0d expected v=1 idx=50", colValid, colIndex);
    end
    reset = 1'b1; step(); reset = 1'b0;
    m_rb = 1'b0; m_par = 1'b0; m_ov = 1'b0;
    compared++;
    if ({memAddress, colValid, colIndex, colDistance, colUV} !== 58'd0 || gpuFlags !== 16'h0001) begin
      mismatched++;
      $display("[TB] FAIL rmid_outputs: got addr=%h v=%b idx=%0d dist=%h uv=%h flags=%h expected zeros flags=0001",
               memAddress, colValid, colIndex, colDistance, colUV, gpuFlags);
    end
    step(); step();
    compared++;
    if (colValid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL rmid_idle: got v=%b expected 0", colValid);
    end
    frameStart = 1'b1; model_frame_start(1'b1); t0 = cyc; step(); frameStart = 1'b0;
    compared++;
    if (memAddress !== 16'hfc00) begin
      mismatched++; $display("[TB] FAIL rmid_restart_addr: got %h expected fc00", memAddress);
    end
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (colValid !== 1'b1 && n < 8) begin step(); n++; end
      compared++;
      if (colValid !== 1'b1 || cyc - t0 != 4 + 4 * i || {colIndex, colDistance, colUV} !== exp_rec(i)) begin
        mismatched++;
        $display("[TB] FAIL rmid_record: got v=%b t=%0d idx=%0d dist=%h uv=%h expected t=%0d rec=%h",
                 colValid, cyc - t0, colIndex, colDistance, colUV, 4 + 4 * i, exp_rec(i));
      end
      step();
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = 16'h0000;
    for (int i = 0; i < COLS; i++) begin
      ram[16'hfc00 + 16'(i)] = 16'h1000 + 16'(i);
      ram[16'hfe00 + 16'(i)] = 16'h2000 + 16'(i);
      ram[16'hf800 + 16'(i)] = 16'($urandom);
      ram[16'hfa00 + 16'(i)] = 16'($urandom);
    end
    test_reset();
    test_full_frame();
    test_second_frame();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
